// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the multicycle RISC-V controller and ALU decoder.
// The TRAP state exists only when ILLEGAL_OP_TRAP_EN is defined.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECR    = 4'd6,
    ST_EXECI    = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_BEQ      = 4'd9,
`ifdef ILLEGAL_OP_TRAP_EN
    ST_JAL      = 4'd10,
    ST_TRAP     = 4'd11
`else
    ST_JAL      = 4'd10
`endif
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/mc_fsm_outdec.sv
// Combinational state-to-control decoder for mc_main_fsm (Moore, except FETCH
// which follows mem_ready). illegal_op exists only with ILLEGAL_OP_TRAP_EN.
module mc_fsm_outdec
  import riscv_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] state,
  input  logic               mem_ready,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic               AdrSrc,
  output logic               IRWrite,
  output logic               PCUpdate,
  output logic               Branch,
  output logic               RegWrite,
  output logic               MemWrite,
`ifdef ILLEGAL_OP_TRAP_EN
  output logic               illegal_op,
`endif
  output logic [1:0]         ALUOp
);

  localparam logic [STATE_W-1:0] FETCH    = STATE_W'(ST_FETCH);
  localparam logic [STATE_W-1:0] DECODE   = STATE_W'(ST_DECODE);
  localparam logic [STATE_W-1:0] MEMADR   = STATE_W'(ST_MEMADR);
  localparam logic [STATE_W-1:0] MEMREAD  = STATE_W'(ST_MEMREAD);
  localparam logic [STATE_W-1:0] MEMWB    = STATE_W'(ST_MEMWB);
  localparam logic [STATE_W-1:0] MEMWRITE = STATE_W'(ST_MEMWRITE);
  localparam logic [STATE_W-1:0] EXECR    = STATE_W'(ST_EXECR);
  localparam logic [STATE_W-1:0] EXECI    = STATE_W'(ST_EXECI);
  localparam logic [STATE_W-1:0] ALUWB    = STATE_W'(ST_ALUWB);
  localparam logic [STATE_W-1:0] BEQ      = STATE_W'(ST_BEQ);
  localparam logic [STATE_W-1:0] JAL      = STATE_W'(ST_JAL);
`ifdef ILLEGAL_OP_TRAP_EN
  localparam logic [STATE_W-1:0] TRAP     = STATE_W'(ST_TRAP);
`endif

  always_comb begin
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCUpdate  = 1'b0;
    Branch    = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    ALUOp     = ALUOP_ADD;
`ifdef ILLEGAL_OP_TRAP_EN
    illegal_op = 1'b0;
`endif
    case (state)
      FETCH: begin
        AdrSrc    = 1'b0;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ALUOp     = ALUOP_ADD;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        PCUpdate  = mem_ready;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
      end
      MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
      end
      MEMREAD: begin
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
      end
      // write strobe stays up until memory acknowledges
      MEMWRITE: begin
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
        MemWrite  = 1'b1;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ALUOp   = ALUOP_FUNCT;
      end
      EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
      end
      ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
      end
      BEQ: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        ALUOp     = ALUOP_SUB;
        ResultSrc = RES_ALUOUT;
        Branch    = 1'b1;
      end
      JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ALUOp     = ALUOP_ADD;
        ResultSrc = RES_ALUOUT;
        PCUpdate  = 1'b1;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      TRAP: illegal_op = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_main_fsm.sv
// Multicycle RISC-V main control FSM: state register, next-state logic and
// reset gating of write enables. ILLEGAL_OP_TRAP_EN adds a sticky TRAP state.
module mc_main_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic               mem_ready,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic               AdrSrc,
  output logic               IRWrite,
  output logic               PCUpdate,
  output logic               Branch,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic [1:0]         ALUOp,
`ifdef ILLEGAL_OP_TRAP_EN
  output logic               illegal_op,
`endif
  output logic [STATE_W-1:0] state_o
);

  // state    | meaning
  // FETCH    | read instruction at PC, PC+4 (waits on mem_ready)
  // DECODE   | read regs, precompute branch target, dispatch on op
  // MEMADR   | rs1 + imm address for lw/sw
  // MEMREAD  | data read (waits on mem_ready)
  // MEMWB    | write loaded data to rd
  // MEMWRITE | data write (waits on mem_ready)
  // EXECR    | R-type ALU op
  // EXECI    | I-type ALU op
  // ALUWB    | write ALUOut to rd
  // BEQ      | compare and conditionally take branch
  // JAL      | PC <- target, link value OldPC+4
  // TRAP     | illegal opcode, held until reset (optional)

  localparam logic [STATE_W-1:0] FETCH    = STATE_W'(ST_FETCH);
  localparam logic [STATE_W-1:0] DECODE   = STATE_W'(ST_DECODE);
  localparam logic [STATE_W-1:0] MEMADR   = STATE_W'(ST_MEMADR);
  localparam logic [STATE_W-1:0] MEMREAD  = STATE_W'(ST_MEMREAD);
  localparam logic [STATE_W-1:0] MEMWB    = STATE_W'(ST_MEMWB);
  localparam logic [STATE_W-1:0] MEMWRITE = STATE_W'(ST_MEMWRITE);
  localparam logic [STATE_W-1:0] EXECR    = STATE_W'(ST_EXECR);
  localparam logic [STATE_W-1:0] EXECI    = STATE_W'(ST_EXECI);
  localparam logic [STATE_W-1:0] ALUWB    = STATE_W'(ST_ALUWB);
  localparam logic [STATE_W-1:0] BEQ      = STATE_W'(ST_BEQ);
  localparam logic [STATE_W-1:0] JAL      = STATE_W'(ST_JAL);
`ifdef ILLEGAL_OP_TRAP_EN
  localparam logic [STATE_W-1:0] TRAP     = STATE_W'(ST_TRAP);
`endif

  logic [STATE_W-1:0] state, state_nxt;
  logic dec_irwrite, dec_pcupdate, dec_branch, dec_regwrite, dec_memwrite;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH:    state_nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_R:         state_nxt = EXECR;
          OP_I:         state_nxt = EXECI;
          OP_BEQ:       state_nxt = BEQ;
          OP_JAL:       state_nxt = JAL;
`ifdef ILLEGAL_OP_TRAP_EN
          default:      state_nxt = TRAP;
`else
          default:      state_nxt = FETCH;
`endif
        endcase
      end
      MEMADR:   state_nxt = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_nxt = mem_ready ? MEMWB : MEMREAD;
      MEMWRITE: state_nxt = mem_ready ? FETCH : MEMWRITE;
      MEMWB:    state_nxt = FETCH;
      EXECR, EXECI, JAL: state_nxt = ALUWB;
      ALUWB:    state_nxt = FETCH;
      BEQ:      state_nxt = FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
      TRAP:     state_nxt = TRAP;
`endif
      default:  state_nxt = FETCH;
    endcase
  end

  mc_fsm_outdec #(.STATE_W(STATE_W)) u_outdec (
    .state      (state),
    .mem_ready  (mem_ready),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .AdrSrc     (AdrSrc),
    .IRWrite    (dec_irwrite),
    .PCUpdate   (dec_pcupdate),
    .Branch     (dec_branch),
    .RegWrite   (dec_regwrite),
    .MemWrite   (dec_memwrite),
`ifdef ILLEGAL_OP_TRAP_EN
    .illegal_op (illegal_op),
`endif
    .ALUOp      (ALUOp)
  );

  // enables drop combinationally so a mid-instruction reset cannot leak a write
  assign IRWrite  = dec_irwrite  & ~reset;
  assign PCUpdate = dec_pcupdate & ~reset;
  assign Branch   = dec_branch   & ~reset;
  assign RegWrite = dec_regwrite & ~reset;
  assign MemWrite = dec_memwrite & ~reset;
  assign state_o  = state;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Directed self-checking bench for mc_main_fsm; covers the TRAP path when
// ILLEGAL_OP_TRAP_EN is defined.
module tb_mc_main_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       mem_ready;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp;
  logic       AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite;
  logic [3:0] state_o;
`ifdef ILLEGAL_OP_TRAP_EN
  logic       illegal_op;
`endif

  int checks = 0;
  int failures = 0;

  mc_main_fsm #(.STATE_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .mem_ready (mem_ready),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .AdrSrc    (AdrSrc),
    .IRWrite   (IRWrite),
    .PCUpdate  (PCUpdate),
    .Branch    (Branch),
    .RegWrite  (RegWrite),
    .MemWrite  (MemWrite),
    .ALUOp     (ALUOp),
`ifdef ILLEGAL_OP_TRAP_EN
    .illegal_op(illegal_op),
`endif
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    op = 7'b0;
    mem_ready = 1'b1;
    #3;
    check("rst_state", 8'(state_o), 8'd0);
    check("rst_irwrite", 8'(IRWrite), 8'd0);
    check("rst_pcupdate", 8'(PCUpdate), 8'd0);
    check("rst_srcb", 8'(ALUSrcB), 8'd2);
    check("rst_resultsrc", 8'(ResultSrc), 8'd2);
    tick();
    reset = 1'b0;
    #1;
    check("fetch_irwrite_rdy", 8'(IRWrite), 8'd1);
    check("fetch_pcupdate_rdy", 8'(PCUpdate), 8'd1);
    mem_ready = 1'b0;
    #1;
    check("fetch_irwrite_wait", 8'(IRWrite), 8'd0);
    tick();
    check("fetch_hold", 8'(state_o), 8'd0);

    // R-type
    mem_ready = 1'b1;
    op = 7'b0110011;
    tick(); check("r_decode", 8'(state_o), 8'd1);
    check("r_decode_aluop", 8'(ALUOp), 8'd0);
    check("r_decode_srca", 8'(ALUSrcA), 8'd1);
    tick(); check("r_execr", 8'(state_o), 8'd6);
    check("r_execr_aluop", 8'(ALUOp), 8'd2);
    check("r_execr_regwrite", 8'(RegWrite), 8'd0);
    check("r_execr_srca", 8'(ALUSrcA), 8'd2);
    check("r_execr_srcb", 8'(ALUSrcB), 8'd0);
    op = 7'b1100011;  // IR changes outside DECODE must be ignored
    tick(); check("r_aluwb", 8'(state_o), 8'd8);
    check("r_aluwb_regwrite", 8'(RegWrite), 8'd1);
    check("r_aluwb_aluop", 8'(ALUOp), 8'd0);
    tick(); check("r_fetch", 8'(state_o), 8'd0);
    check("r_fetch_regwrite", 8'(RegWrite), 8'd0);

    // I-type
    op = 7'b0010011;
    tick(); tick(); check("i_execi", 8'(state_o), 8'd7);
    check("i_execi_srcb", 8'(ALUSrcB), 8'd1);
    tick(); check("i_aluwb", 8'(state_o), 8'd8);
    tick(); check("i_fetch", 8'(state_o), 8'd0);

    // lw with two wait cycles in MEMREAD
    op = 7'b0000011;
    tick(); check("lw_decode", 8'(state_o), 8'd1);
    tick(); check("lw_memadr", 8'(state_o), 8'd2);
    check("lw_memadr_srca", 8'(ALUSrcA), 8'd2);
    check("lw_memadr_srcb", 8'(ALUSrcB), 8'd1);
    tick(); check("lw_memread1", 8'(state_o), 8'd3);
    check("lw_memread_adrsrc", 8'(AdrSrc), 8'd1);
    mem_ready = 1'b0;
    tick(); check("lw_memread2", 8'(state_o), 8'd3);
    tick(); check("lw_memread3", 8'(state_o), 8'd3);
    mem_ready = 1'b1;
    tick(); check("lw_memwb", 8'(state_o), 8'd4);
    check("lw_memwb_resultsrc", 8'(ResultSrc), 8'd1);
    check("lw_memwb_regwrite", 8'(RegWrite), 8'd1);
    tick(); check("lw_fetch", 8'(state_o), 8'd0);

    // sw, no waits
    op = 7'b0100011;
    tick(); check("sw_decode", 8'(state_o), 8'd1);
    tick(); check("sw_memadr", 8'(state_o), 8'd2);
    check("sw_memadr_memwrite", 8'(MemWrite), 8'd0);
    tick(); check("sw_memwrite", 8'(state_o), 8'd5);
    check("sw_memwrite_we", 8'(MemWrite), 8'd1);
    check("sw_memwrite_adrsrc", 8'(AdrSrc), 8'd1);
    tick(); check("sw_fetch", 8'(state_o), 8'd0);
    check("sw_fetch_we", 8'(MemWrite), 8'd0);

    // beq
    op = 7'b1100011;
    tick(); tick(); check("beq_state", 8'(state_o), 8'd9);
    check("beq_aluop", 8'(ALUOp), 8'd1);
    check("beq_branch", 8'(Branch), 8'd1);
    check("beq_srca", 8'(ALUSrcA), 8'd2);
    check("beq_srcb", 8'(ALUSrcB), 8'd0);
    tick(); check("beq_fetch", 8'(state_o), 8'd0);
    check("beq_fetch_branch", 8'(Branch), 8'd0);

    // jal
    op = 7'b1101111;
    tick(); tick(); check("jal_state", 8'(state_o), 8'd10);
    check("jal_pcupdate", 8'(PCUpdate), 8'd1);
    check("jal_srca", 8'(ALUSrcA), 8'd1);
    check("jal_srcb", 8'(ALUSrcB), 8'd2);
    tick(); check("jal_aluwb", 8'(state_o), 8'd8);
    check("jal_aluwb_pcupdate", 8'(PCUpdate), 8'd0);
    tick(); check("jal_fetch", 8'(state_o), 8'd0);

    // reset mid-EXECR and mid-ALUWB
    op = 7'b0110011;
    tick(); tick(); check("rst_pre_execr", 8'(state_o), 8'd6);
    reset = 1'b1;
    #1;
    check("rst_mid_execr_state", 8'(state_o), 8'd0);
    check("rst_mid_execr_regwrite", 8'(RegWrite), 8'd0);
    check("rst_mid_irwrite", 8'(IRWrite), 8'd0);
    reset = 1'b0;
    #1;
    check("rst_release_irwrite", 8'(IRWrite), 8'd1);
    tick(); tick(); tick(); check("rst_pre_aluwb", 8'(state_o), 8'd8);
    check("rst_pre_aluwb_regwrite", 8'(RegWrite), 8'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_aluwb_regwrite", 8'(RegWrite), 8'd0);
    check("rst_mid_aluwb_state", 8'(state_o), 8'd0);
    reset = 1'b0;

    // reset while a store is stalled
    op = 7'b0100011;
    mem_ready = 1'b1;
    tick(); tick(); tick(); check("sw2_memwrite", 8'(state_o), 8'd5);
    mem_ready = 1'b0;
    tick(); check("sw2_hold", 8'(state_o), 8'd5);
    check("sw2_hold_we", 8'(MemWrite), 8'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_sw_we", 8'(MemWrite), 8'd0);
    reset = 1'b0;
    mem_ready = 1'b1;

    // unrecognised opcode
    op = 7'b1111111;
    tick(); check("ill_decode", 8'(state_o), 8'd1);
    tick();
`ifdef ILLEGAL_OP_TRAP_EN
    check("ill_trap", 8'(state_o), 8'd11);
    for (int i = 0; i < 10; i++) tick();
    check("ill_trap_hold", 8'(state_o), 8'd11);
    check("ill_flag", 8'(illegal_op), 8'd1);
    check("ill_trap_pcupdate", 8'(PCUpdate), 8'd0);
    reset = 1'b1;
    #1;
    check("ill_rst_state", 8'(state_o), 8'd0);
    check("ill_rst_flag", 8'(illegal_op), 8'd0);
    reset = 1'b0;
`else
    check("ill_nop_fetch", 8'(state_o), 8'd0);
    check("ill_nop_regwrite", 8'(RegWrite), 8'd0);
`endif
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
